i2s_tx_stream: RTL and testbench

Parametrised I2S / left-justified serial audio transmitter with a valid/ready sample interface. It sits between an audio sample source (tone generator, sample FIFO) and the external DAC, generating master, bit and word-select clocks from the system clock. It supersedes the fixed 16-bit always-loaded speaker driver with:
- configurable sample width, slot width and clock ratios,
- a real serial clock,
- one-entry sample buffering with back-pressure,
- mute and underrun reporting.

---
 rtl/i2s_tx_stream.sv | 82 ++++++++
 tb/tb_i2s_tx_stream.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_stream.sv
// i2s_tx_stream: I2S / left-justified audio transmitter generating mclk, sck and lrck from clk,
// with a one-pair pending buffer in front of the active frame register.
module i2s_tx_stream #(
    parameter int DATA_W    = 16,
    parameter int SLOT_BITS = 16,
    parameter int BIT_DIV   = 16,
    parameter int MCLK_DIV  = 4,
    parameter int MODE      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    input  logic              mute,
    output logic              audio_mclk,
    output logic              audio_lrck,
    output logic              audio_sck,
    output logic              audio_sdin,
    output logic              frame_start,
    output logic              underrun
);
    localparam int FB = 2 * SLOT_BITS;
    localparam int BW = $clog2(FB);
    localparam int DW = $clog2(BIT_DIV);
    localparam int MW = $clog2(MCLK_DIV);

    logic [MW-1:0]     mclk_cnt;
    logic [DW-1:0]     dcnt;
    logic [BW-1:0]     bcnt;
    logic [DATA_W-1:0] pend_l, pend_r, act_l, act_r;
    logic              pend_full, prev_bit, bit_end, boundary, accept;
    logic [FB-1:0]     frame_bits;
    logic [BW-1:0]     lj_idx, i2s_idx;

    assign bit_end  = dcnt == DW'(BIT_DIV - 1);
    assign boundary = bit_end && bcnt == BW'(FB - 1);
    assign accept   = s_valid && s_ready;
    // stream bit k sits at frame_bits[FB-1-k]: MSB first, zero padded per slot
    assign frame_bits = {SLOT_BITS'(act_l) << (SLOT_BITS - DATA_W), SLOT_BITS'(act_r) << (SLOT_BITS - DATA_W)};
    assign lj_idx     = BW'(FB - 1) - bcnt;
    assign i2s_idx    = lj_idx + BW'(1);

    assign s_ready     = !pend_full;
    assign audio_mclk  = mclk_cnt >= MW'(MCLK_DIV / 2);
    assign audio_sck   = dcnt >= DW'(BIT_DIV / 2);
    assign audio_lrck  = bcnt >= BW'(SLOT_BITS);
    assign frame_start = bcnt == '0 && dcnt == '0;
    assign underrun    = boundary && !pend_full;
    // I2S delays data one bit, so bcnt=0 carries the previous frame's last bit
    assign audio_sdin  = MODE == 1 ? frame_bits[lj_idx] : (bcnt == '0 ? prev_bit : frame_bits[i2s_idx]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mclk_cnt  <= '0;
            dcnt      <= '0;
            bcnt      <= '0;
            pend_l    <= '0;
            pend_r    <= '0;
            act_l     <= '0;
            act_r     <= '0;
            pend_full <= 1'b0;
            prev_bit  <= 1'b0;
        end else begin
            mclk_cnt <= mclk_cnt == MW'(MCLK_DIV - 1) ? '0 : mclk_cnt + MW'(1);
            dcnt     <= bit_end ? '0 : dcnt + DW'(1);
            if (bit_end)
                bcnt <= bcnt == BW'(FB - 1) ? '0 : bcnt + BW'(1);
            if (boundary) begin
                act_l    <= pend_full && !mute ? pend_l : '0;
                act_r    <= pend_full && !mute ? pend_r : '0;
                prev_bit <= frame_bits[0];
            end
            if (accept) begin
                pend_l <= s_left;
                pend_r <= s_right;
            end
            pend_full <= accept ? 1'b1 : (boundary ? 1'b0 : pend_full);
        end
    end
endmodule

// File: tb/tb_i2s_tx_stream.sv
// tb_i2s_tx_stream: scoreboard bench for i2s_tx_stream in the default I2S setup and in a
// left-justified 24-in-32 setup; expected serial bits are queued up front and popped per sck rise.
module tb_i2s_tx_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_valid, a_ready, a_mute, a_mclk, a_lrck, a_sck, a_sdin, a_fs, a_ur;
    logic [15:0] a_l, a_r;
    logic        b_valid, b_ready, b_mute, b_mclk, b_lrck, b_sck, b_sdin, b_fs, b_ur;
    logic [23:0] b_l, b_r;

    i2s_tx_stream dut_a (
        .clk(clk), .rst(rst), .s_valid(a_valid), .s_ready(a_ready), .s_left(a_l), .s_right(a_r),
        .mute(a_mute), .audio_mclk(a_mclk), .audio_lrck(a_lrck), .audio_sck(a_sck),
        .audio_sdin(a_sdin), .frame_start(a_fs), .underrun(a_ur)
    );

    i2s_tx_stream #(.DATA_W(24), .SLOT_BITS(32), .BIT_DIV(4), .MCLK_DIV(2), .MODE(1)) dut_b (
        .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready), .s_left(b_l), .s_right(b_r),
        .mute(b_mute), .audio_mclk(b_mclk), .audio_lrck(b_lrck), .audio_sck(b_sck),
        .audio_sdin(b_sdin), .frame_start(b_fs), .underrun(b_ur)
    );

    int tests = 0, fails = 0, n = 0, epoch = 0;
    int under_cnt = 0, lrck_edges = 0, sck_rises = 0, mclk_rises = 0;
    bit qa[$];
    bit qb[$];

    always @(posedge clk or posedge rst) n <= rst ? 0 : n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
        end
    endtask

    task automatic push_a(input logic [31:0] f);
        for (int i = 31; i >= 0; i--) qa.push_back(f[i]);
    endtask

    task automatic push_b(input logic [23:0] l, input logic [23:0] r);
        logic [63:0] f;
        f = {l, 8'h00, r, 8'h00};
        for (int i = 63; i >= 0; i--) qb.push_back(f[i]);
    endtask

    task automatic wait_n(input int t);
        while (n < t) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_s_ready"}, 32'(a_ready), 1);
        chk({tag, "_mclk"}, 32'(a_mclk), 0);
        chk({tag, "_sck"}, 32'(a_sck), 0);
        chk({tag, "_lrck"}, 32'(a_lrck), 0);
        chk({tag, "_sdin"}, 32'(a_sdin), 0);
        chk({tag, "_underrun"}, 32'(a_ur), 0);
        chk({tag, "_frame_start"}, 32'(a_fs), 1);
        chk({tag, "_b_ready"}, 32'(b_ready), 1);
        chk({tag, "_b_frame_start"}, 32'(b_fs), 1);
    endtask

    // Monitor: scoreboard pops on every sck rise, plus clock-phase and underrun checks
    initial begin
        logic pa, pb, pl, pm;
        pa = 0; pb = 0; pl = 0; pm = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pa = 0; pb = 0; pl = 0; pm = 0;
            end else begin
                if (a_sck && !pa) begin
                    sck_rises++;
                    chk("a_sck_phase", n % 16, 8);
                    if (qa.size() > 0) chk("a_sdin", 32'(a_sdin), 32'(qa.pop_front()));
                end
                if (b_sck && !pb && qb.size() > 0) chk("b_sdin", 32'(b_sdin), 32'(qb.pop_front()));
                if (a_lrck != pl) begin
                    lrck_edges++;
                    chk("a_lrck_edge_phase", n % 256, 0);
                end
                if (a_mclk && !pm) begin
                    mclk_rises++;
                    chk("a_mclk_phase", n % 4, 2);
                end
                if (a_ur) begin
                    under_cnt++;
                    chk("a_underrun_at", n, epoch == 0 ? 1023 : 511);
                end
                pa = a_sck; pb = b_sck; pl = a_lrck; pm = a_mclk;
            end
        end
    end

    initial begin
        int t0;
        a_valid = 0; a_l = '0; a_r = '0; a_mute = 0;
        b_valid = 0; b_l = '0; b_r = '0; b_mute = 0;
        qa.push_back(1'b0);
        push_a(32'h0);
        push_a(32'hA5F0_0F0F);
        push_a(32'h0);
        push_a(32'h4000_5000);
        push_a(32'h4001_5001);
        push_a(32'h4002_5002);
        push_a(32'h0);
        push_a(32'h7FFF_C3A5);
        push_b(24'h0, 24'h0);
        push_b(24'h800001, 24'h123456);
        push_b(24'h0, 24'h0);
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 0;

        wait_n(5);
        b_valid = 1; b_l = 24'h800001; b_r = 24'h123456;
        chk("b_ready_before_accept", 32'(b_ready), 1);
        wait_n(6);
        b_valid = 0;
        chk("b_ready_after_accept", 32'(b_ready), 0);

        wait_n(20);
        a_valid = 1; a_l = 16'hA5F0; a_r = 16'h0F0F;
        chk("a_ready_before_accept", 32'(a_ready), 1);
        wait_n(21);
        a_valid = 0;
        chk("a_ready_after_accept", 32'(a_ready), 0);

        wait_n(255);
        chk("b_underrun_pending_full", 32'(b_ur), 0);
        wait_n(256);
        chk("b_ready_after_boundary", 32'(b_ready), 1);
        wait_n(511);
        chk("a_ready_held_low", 32'(a_ready), 0);
        chk("a_underrun_pending_full", 32'(a_ur), 0);
        chk("b_underrun_empty", 32'(b_ur), 1);
        wait_n(512);
        chk("a_frame_start_1", 32'(a_fs), 1);
        chk("a_ready_after_boundary", 32'(a_ready), 1);
        wait_n(513);
        chk("a_frame_start_width", 32'(a_fs), 0);
        wait_n(767);
        chk("a_lrck_767", 32'(a_lrck), 0);
        wait_n(768);
        chk("a_lrck_768", 32'(a_lrck), 1);
        wait_n(1023);
        chk("a_lrck_1023", 32'(a_lrck), 1);
        chk("a_underrun_boundary", 32'(a_ur), 1);
        wait_n(1024);
        chk("a_lrck_1024", 32'(a_lrck), 0);
        chk("a_underrun_width", 32'(a_ur), 0);
        chk("a_ready_after_underrun", 32'(a_ready), 1);

        wait_n(1030);
        a_valid = 1; a_l = 16'h4000; a_r = 16'h5000;
        for (int i = 0; i < 3; i++) begin
            t0 = n;
            while (!a_ready && n < t0 + 1200) @(negedge clk);
            chk("bp_accept_frame", n / 512, 2 + i);
            @(posedge clk);
            #1;
            a_l = a_l + 16'd1; a_r = a_r + 16'd1;
            if (i == 2) a_valid = 0;
            @(negedge clk);
            chk("bp_ready_low_after_accept", 32'(a_ready), 0);
        end

        wait_n(2600);
        a_valid = 1; a_l = 16'h1234; a_r = 16'h8001;
        chk("mute_pair_ready", 32'(a_ready), 1);
        wait_n(2601);
        a_valid = 0;
        wait_n(2700);
        a_mute = 1;
        wait_n(2710);
        a_mute = 0;
        wait_n(3071);
        a_mute = 1;
        chk("mute_pending_full", 32'(a_ready), 0);
        wait_n(3072);
        a_mute = 0;
        chk("mute_pending_consumed", 32'(a_ready), 1);
        wait_n(3076);
        chk("lrck_edge_count", lrck_edges, 12);
        chk("sck_rise_count", sck_rises, 192);
        chk("mclk_rise_count", mclk_rises, 769);

        wait_n(3100);
        a_valid = 1; a_l = 16'h7FFF; a_r = 16'hC3A5;
        wait_n(3101);
        a_valid = 0;
        wait_n(3600);
        a_valid = 1; a_l = 16'hDEAD; a_r = 16'hBEEF;
        wait_n(3601);
        a_valid = 0;
        chk("pre_reset_pending_full", 32'(a_ready), 0);

        wait_n(3747);
        #1;
        rst = 1;
        epoch = 1;
        qa.delete();
        qa.push_back(1'b0);
        push_a(32'h0);
        #1;
        check_reset("mid");
        repeat (2) @(negedge clk);
        rst = 0;
        wait_n(1);
        chk("reset_discards_pending", 32'(a_ready), 1);
        wait_n(530);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        chk("underrun_total", under_cnt, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
